frac_lut4_cfg_loader: RTL and testbench

FRAC_LUT4_CFG_LOADER -- requirements
Module: frac_lut4_cfg_loader

---
 rtl/frac_lut4_cfg_loader_pkg.sv | 22 ++
 rtl/frac_lut4_cfg_loader_cfg_shift_stage.sv | 45 ++++
 rtl/frac_lut4_cfg_loader.sv | 130 +++++++++++++
 tb/tb_frac_lut4_cfg_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_lut4_cfg_loader_pkg.sv
// ============================================================================
//  Module      : frac_lut4_cfg_loader_pkg
//  Description : Shared state encoding and frame-length helper for the
//                configuration loaders.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frac_lut4_cfg_loader_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    // Payload bits followed by a single even-parity bit.
    function automatic int frame_len(input int num_sram, input int num_mode);
        return num_sram + num_mode + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frac_lut4_cfg_loader_cfg_shift_stage.sv
// ============================================================================
//  Module      : cfg_shift_stage
//  Description : Staging register for an incoming frame plus running parity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_shift_stage #(
    parameter int DATA_W = 17,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic [IDX_W-1:0]  i_bit_idx,
    input  logic              i_bit,
    output logic [0:DATA_W-1] o_data,
    output logic              o_parity_ok
);

    logic [0:DATA_W-1] r_data;
    logic              r_parity;

    // The parity bit itself lands past the payload, so it only feeds r_parity.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_data   <= '0;
            r_parity <= 1'b0;
        end else if (i_shift_en) begin
            r_parity <= r_parity ^ i_bit;
            for (int i = 0; i < DATA_W; i++) begin
                if (int'(i_bit_idx) == i) begin
                    r_data[i] <= i_bit;
                end
            end
        end
    end

    assign o_data      = r_data;
    assign o_parity_ok = ~r_parity;

endmodule

`default_nettype wire

// File: rtl/frac_lut4_cfg_loader.sv
// ============================================================================
//  Module      : frac_lut4_cfg_loader
//  Description : Serial loader for a fracturable LUT4 truth table and mode
//                bits, committing a frame only when its even parity checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_lut4_cfg_loader
    import frac_lut4_cfg_loader_pkg::*;
#(
    parameter int NUM_SRAM = 16,
    parameter int NUM_MODE = 1
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                cfg_in,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_abort,
    output logic [0:NUM_SRAM-1] sram,
    output logic [0:NUM_SRAM-1] sram_inv,
    output logic [0:NUM_MODE-1] mode,
    output logic [0:NUM_MODE-1] mode_inv,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                cfg_busy
);

    localparam int c_FRAME_LEN = frame_len(NUM_SRAM, NUM_MODE);
    localparam int c_DATA_W    = NUM_SRAM + NUM_MODE;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN);

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [0:NUM_SRAM-1] r_sram;
    logic [0:NUM_MODE-1] r_mode;
    logic                r_done;
    logic                r_err;

    logic                w_ready;
    logic                w_abort;
    logic                w_accept;
    logic                w_last;
    logic                w_stage_clear;
    logic [0:c_DATA_W-1] w_stage;
    logic                w_parity_ok;

    assign w_ready       = !prog_reset && (r_state != c_ST_COMMIT);
    assign w_abort       = cfg_abort && (r_state == c_ST_SHIFT);
    assign w_accept      = cfg_valid && w_ready && !cfg_abort;
    assign w_last        = (r_cnt == c_CNT_W'(c_FRAME_LEN - 1));
    assign w_stage_clear = w_abort || (r_state == c_ST_COMMIT);

    cfg_shift_stage #(
        .DATA_W (c_DATA_W),
        .IDX_W  (c_CNT_W)
    ) u_stage (
        .clk         (prog_clk),
        .rst         (prog_reset),
        .i_clear     (w_stage_clear),
        .i_shift_en  (w_accept),
        .i_bit_idx   (r_cnt),
        .i_bit       (cfg_in),
        .o_data      (w_stage),
        .o_parity_ok (w_parity_ok)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_sram  <= '0;
            r_mode  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_SHIFT;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                c_ST_SHIFT: begin
                    if (w_abort) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        // Counter parks on the last index until COMMIT ends.
                        if (w_last) begin
                            r_state <= c_ST_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_ST_COMMIT: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    if (w_parity_ok) begin
                        r_sram <= w_stage[0:NUM_SRAM-1];
                        r_mode <= w_stage[NUM_SRAM +: NUM_MODE];
                        r_done <= 1'b1;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cfg_ready = w_ready;
    assign cfg_busy  = (r_state != c_ST_IDLE);
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign sram      = r_sram;
    assign sram_inv  = ~r_sram;
    assign mode      = r_mode;
    assign mode_inv  = ~r_mode;

endmodule

`default_nettype wire

// File: tb/tb_frac_lut4_cfg_loader.sv
// ============================================================================
//  Module      : tb_frac_lut4_cfg_loader
//  Description : Directed self-checking bench for frac_lut4_cfg_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frac_lut4_cfg_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset;
    logic        cfg_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_abort;
    logic [0:15] sram;
    logic [0:15] sram_inv;
    logic [0:0]  mode;
    logic [0:0]  mode_inv;
    logic        cfg_done;
    logic        cfg_err;
    logic        cfg_busy;

    int n_cmp    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    bit both_seen = 1'b0;
    bit inv_bad   = 1'b0;

    frac_lut4_cfg_loader #(
        .NUM_SRAM (16),
        .NUM_MODE (1)
    ) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .cfg_in     (cfg_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_abort  (cfg_abort),
        .sram       (sram),
        .sram_inv   (sram_inv),
        .mode       (mode),
        .mode_inv   (mode_inv),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cfg_busy   (cfg_busy)
    );

    always #5 prog_clk = ~prog_clk;

    always @(negedge prog_clk) begin
        if (cfg_done) done_cnt++;
        if (cfg_err) err_cnt++;
        if (cfg_done && cfg_err) both_seen = 1'b1;
        if ((sram_inv !== ~sram) || (mode_inv !== ~mode)) inv_bad = 1'b1;
    end

    function automatic logic [0:17] mk_frame(input logic [0:15] s, input logic m, input logic p);
        return {s, m, p};
    endfunction

    // Presents n bits with cfg_valid held high, waiting out cfg_ready=0 cycles.
    task automatic send_bits(input logic [0:35] b, input int n, output int stalls);
        bit ok;
        int guard;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_in    = b[k];
            ok        = 1'b0;
            guard     = 0;
            while (!ok) begin
                @(negedge prog_clk);
                ok = cfg_ready;
                @(posedge prog_clk);
                #1;
                if (!ok) stalls++;
                guard++;
                if (!ok && guard > 20) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL send_bits_timeout: cfg_ready stuck at %b, required 1", cfg_ready);
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        cfg_valid  = 1'b0;
        cfg_abort  = 1'b0;
        cfg_in     = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0", cfg_ready);
        end
        n_cmp++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/err got %b%b%b, required 000", cfg_busy, cfg_done, cfg_err);
        end
        prog_reset = 1'b0;
        repeat (5) @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'h0000 || sram_inv !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL idle_sram: got %h/%h, required 0000/ffff", sram, sram_inv);
        end
        n_cmp++;
        if (mode !== 1'b0 || mode_inv !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_mode: got %b/%b, required 0/1", mode, mode_inv);
        end
        n_cmp++;
        if (cfg_ready !== 1'b1 || done_cnt != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_ready_pulses: ready %b done %0d err %0d, required 1 0 0", cfg_ready, done_cnt, err_cnt);
        end
    endtask

    task automatic test_frame();
        int st;
        int d0;
        d0 = done_cnt;
        send_bits({mk_frame(16'hA5C3, 1'b1, 1'b1), 18'b0}, 18, st);
        cfg_valid = 1'b0;
        // One edge after the last bit: in COMMIT, outputs not yet loaded.
        n_cmp++;
        if (cfg_busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_state: busy %b ready %b, required 1 0", cfg_busy, cfg_ready);
        end
        n_cmp++;
        if (sram !== 16'h0000 || cfg_done !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_early: sram %h done %b, required 0000 0", sram, cfg_done);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'hA5C3 || sram_inv !== 16'h5A3C) begin
            n_fail++;
            $display("FAIL frame_sram: got %h/%h, required a5c3/5a3c", sram, sram_inv);
        end
        n_cmp++;
        if (mode !== 1'b1 || mode_inv !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_mode: got %b/%b, required 1/0", mode, mode_inv);
        end
        n_cmp++;
        if (cfg_done !== 1'b1 || cfg_err !== 1'b0 || cfg_busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_pulse: done %b err %b busy %b ready %b, required 1 0 0 1",
                     cfg_done, cfg_err, cfg_busy, cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (cfg_done !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL frame_pulse_width: done %b count %0d, required 0 1", cfg_done, done_cnt - d0);
        end
    endtask

    task automatic test_parity_err();
        int st;
        int e0;
        int d0;
        e0 = err_cnt;
        d0 = done_cnt;
        send_bits({mk_frame(16'hA5C3, 1'b1, 1'b0), 18'b0}, 18, st);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_pulse: err %b done %b, required 1 0", cfg_err, cfg_done);
        end
        // A bad frame carrying different data must not disturb the table.
        send_bits({mk_frame(16'h0F0F, 1'b0, 1'b1), 18'b0}, 18, st);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'hA5C3 || mode !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_hold: sram %h mode %b, required a5c3 1", sram, mode);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (cfg_err !== 1'b0 || err_cnt - e0 != 2 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL perr_count: err %b errs %0d dones %0d, required 0 2 0",
                     cfg_err, err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int st;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits({mk_frame(16'hFFFF, 1'b1, 1'b1), 18'b0}, 9, st);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_in    = 1'b1;
        @(posedge prog_clk);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        n_cmp++;
        if (cfg_busy !== 1'b0 || sram !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL abort_idle: busy %b sram %h, required 0 a5c3", cfg_busy, sram);
        end
        send_bits({mk_frame(16'h0001, 1'b0, 1'b1), 18'b0}, 18, st);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'h0001 || mode !== 1'b0 || mode_inv !== 1'b1 || cfg_done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next: sram %h mode %b inv %b done %b, required 0001 0 1 1",
                     sram, mode, mode_inv, cfg_done);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL abort_count: dones %0d errs %0d, required 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits({mk_frame(16'h1234, 1'b0, 1'b1), mk_frame(16'hA5C3, 1'b1, 1'b1)}, 36, st);
        cfg_valid = 1'b0;
        n_cmp++;
        if (st != 1) begin
            n_fail++;
            $display("FAIL b2b_stalls: got %0d, required 1", st);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'hA5C3 || mode !== 1'b1 || cfg_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: sram %h mode %b done %b, required a5c3 1 1", sram, mode, cfg_done);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (done_cnt - d0 != 2 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL b2b_count: dones %0d errs %0d, required 2 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits({mk_frame(16'hFFFF, 1'b0, 1'b0), 18'b0}, 12, st);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b, required 0", cfg_ready);
        end
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'h0000 || sram_inv !== 16'hFFFF || mode !== 1'b0 || mode_inv !== 1'b1 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: sram %h inv %h mode %b busy %b, required 0000 ffff 0 0",
                     sram, sram_inv, mode, cfg_busy);
        end
        @(posedge prog_clk);
        #1;
        prog_reset = 1'b0;
        cfg_valid  = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        n_cmp++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL rstmid_pulses: dones %0d errs %0d, required 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_bits({mk_frame(16'h8001, 1'b1, 1'b1), 18'b0}, 18, st);
        cfg_valid = 1'b0;
        @(posedge prog_clk);
        #1;
        n_cmp++;
        if (sram !== 16'h8001 || mode !== 1'b1 || cfg_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_next: sram %h mode %b done %b, required 8001 1 1", sram, mode, cfg_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_parity_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge prog_clk);
        #1;
        n_cmp++;
        if (both_seen) begin
            n_fail++;
            $display("FAIL done_err_overlap: got 1, required 0");
        end
        n_cmp++;
        if (inv_bad) begin
            n_fail++;
            $display("FAIL inv_consistency: got 1, required 0");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
